// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers words written from BusC in a small circular FIFO
// and sends each one as an 8N1 UART frame (LSB first) on sTx.
// Frames queued behind one another go out with no idle gap between them.
module result_uart_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int DATAWIDTH = 8,
   parameter int FIFODEPTH = 4
) (
   input  logic                 clk,
   input  logic                 lowRst,
   input  logic                 lowWr,
   input  logic [DATAWIDTH-1:0] DataIn,
   output logic                 sTx,
   output logic                 sBusy,
   output logic                 sEmpty,
   output logic                 sFull,
   output logic                 sDrop
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW   = $clog2(FIFODEPTH);
   localparam int CNTW = PW + 1;
   localparam logic [CW-1:0]   TMAX = CW'(DIV - 1);
   localparam logic [CNTW-1:0] CMAX = CNTW'(FIFODEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FSM registers and their next values
   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_timer, w_timer_nxt;
   logic [2:0]           r_idx,   w_idx_nxt;
   logic [DATAWIDTH-1:0] r_sh,    w_sh_nxt;
   logic                 r_tx,    w_tx_nxt;

   // FIFO storage and bookkeeping
   logic [DATAWIDTH-1:0] r_mem [FIFODEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CNTW-1:0]      r_count;
   logic                 r_drop;

   logic w_empty;
   logic w_full;
   logic w_bit_end;
   logic w_pop;
   logic w_wr_ok;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CMAX);
   assign w_bit_end = (r_timer == TMAX);

   // A write is taken when there is room, or when a pop frees a slot in the same cycle
   assign w_wr_ok = !lowWr && (!w_full || w_pop);

   assign sTx    = r_tx;
   assign sBusy  = (r_state != IDLE);
   assign sEmpty = w_empty;
   assign sFull  = w_full;
   assign sDrop  = r_drop;

   // Next-state logic: bit timing, shifting, FIFO pops and the registered line value
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = w_bit_end ? '0 : r_timer + CW'(1);
      w_idx_nxt   = r_idx;
      w_sh_nxt    = r_sh;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            w_timer_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_sh_nxt    = r_mem[r_rptr];
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt = DATA;
               w_idx_nxt   = 3'd0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_sh_nxt  = {1'b0, r_sh[DATAWIDTH-1:1]};
               w_idx_nxt = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (!w_empty) begin
                  // chain straight into the next start bit
                  w_pop       = 1'b1;
                  w_sh_nxt    = r_mem[r_rptr];
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
         end
      endcase

      // The line is registered from the state being entered, so sTx never glitches
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_sh_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // FSM state register; reset abandons any partial frame and idles the line high
   always_ff @(posedge clk) begin
      if (!lowRst) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_idx   <= 3'd0;
         r_sh    <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_idx   <= w_idx_nxt;
         r_sh    <= w_sh_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // FIFO pointers, occupancy count and the sticky overflow flag
   always_ff @(posedge clk) begin
      if (!lowRst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_drop  <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_wr_ok, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase
         if (!lowWr && w_full && !w_pop) begin
            r_drop <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers and count do
   always_ff @(posedge clk) begin
      if (lowRst && w_wr_ok) begin
         r_mem[r_wptr] <= DataIn;
      end
   end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serial result port for the 8-bit datapath. Accepts data words written from BusC with an active-low write strobe, the same strobe style the register-file decoder outputs use. Buffers them in a small FIFO and transmits each one as an 8N1 UART frame on a single output pin. It is the outbound counterpart of the `start` input: the state machine selects it as a destination register, and the host receives the computed results.

## Interface
Parameters:
- `CLK_FREQ`, default 50000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `DATAWIDTH`, default 8: word width. Only 8 is supported.
- `FIFODEPTH`, default 4: buffer depth in words. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: system clock. All logic runs on the rising edge.
- `lowRst`, in, 1: reset, synchronous, active-low.
- `lowWr`, in, 1: write strobe, active-low. `DataIn` is captured on every rising edge where `lowWr`=0.
- `DataIn`, in, 8: word to enqueue, driven from BusC.
- `sTx`, out, 1: UART serial line. Idles high.
- `sBusy`, out, 1: high while the FSM is not in IDLE.
- `sEmpty`, out, 1: FIFO empty.
- `sFull`, out, 1: FIFO full.
- `sDrop`, out, 1: sticky flag. Set when a write is rejected because the FIFO is full. Cleared only by reset.

## Operation
- Bit period: DIV = CLK_FREQ/BAUD, using integer truncation. DIV must be at least 2. The bit counter counts 0..DIV-1 and then wraps.
- FIFO:
  - Circular buffer with write and read pointers of log2(FIFODEPTH) bits, plus an occupancy count of 0..FIFODEPTH.
  - `sEmpty` = (count==0). `sFull` = (count==FIFODEPTH).
  - Pointers wrap modulo FIFODEPTH.
- Write rules:
  - `lowWr`=0 with not full: store the word, advance the write pointer, count+1.
  - `lowWr`=0 with full and no pop in the same cycle: word discarded, `sDrop` set to 1, count unchanged.
  - `lowWr`=0 with full and a pop in the same cycle: write accepted, count unchanged.
  - Write and pop in the same cycle with not full: both happen, count unchanged.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: `sTx`=1. If the FIFO is non-empty: pop the head into shift register `sh`, clear the bit timer, go to START.
  - START: `sTx`=0 for DIV cycles, then go to DATA with bit index = 0.
  - DATA: `sTx`=`sh[0]` for DIV cycles. At the end of each bit period, shift `sh` right and increment the index. After index 7 completes, go to STOP.
  - STOP: `sTx`=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap). Otherwise go to IDLE.
- Bit order is LSB first. There is no parity and one stop bit.
- `sTx` is driven from a register and is glitch-free.

## Timing
- Reset values, taking effect at the edge where `lowRst`=0:
  - `sTx`=1, `sBusy`=0, `sEmpty`=1, `sFull`=0, `sDrop`=0.
  - FSM in IDLE; pointers, count and timers at 0.
  - The FIFO contents are discarded.
- Reset mid-frame: at the next edge, `sTx` returns to 1 and the partial frame is abandoned. No completion is guaranteed.
- A write and reset in the same cycle: reset wins and the word is lost.
- Write latency:
  - Write sampled at edge E0.
  - `sEmpty` falls after E0.
  - At E1 the FSM pops: `sTx` falls to 0 and `sBusy` rises after E1.
  - If nothing else was written, `sEmpty` returns to 1 after E1.
- Frame length: exactly 10·DIV cycles from the `sTx` falling edge to the end of the stop bit.
- With back-to-back frames, the next start bit begins at the edge immediately after the last stop-bit cycle. The period is 10·DIV cycles per word.
- `sBusy` falls in the cycle after the last stop-bit cycle, but only when the FIFO is empty at that point.
- `sFull` and `sEmpty` are registered and valid one cycle after the causing edge. The producer must check `sFull` before asserting `lowWr`.

## Test plan
Test parameters: CLK_FREQ=1000, BAUD=100, so DIV=10 and one frame is 100 cycles.

- Reset check: hold `lowRst`=0 for 3 cycles with `lowWr` toggling.
  - Required: `sTx`=1, `sEmpty`=1, `sFull`=0, `sBusy`=0, `sDrop`=0 throughout.
  - Required: no frame starts after release.
- Single word: write 0x57 in one cycle.
  - Required: `sTx` falls 1 cycle later.
  - Required: sampled at bit centres, the line reads 0, 1,1,1,0,1,0,1,0, 1.
  - Required: `sBusy` is high for exactly 100 cycles, then `sTx` stays 1.
- Back-to-back: write 0xA5, then 0x3C on consecutive cycles.
  - Required: two frames, 200 cycles total, with the second start bit immediately after the first stop bit.
  - Required: the data bits decode as 0xA5 then 0x3C.
- Fill and overflow: write 0x01–0x05 on 5 consecutive cycles while idle.
  - The first word is popped at E1, so the FIFO holds 4 words.
  - Required: `sFull`=1. The 5th write is discarded only if no pop coincides with it.
  - Required: with DEPTH=4 the words 0x01–0x05 all transmit and `sDrop`=0, because the pop at E1 makes room.
  - Repeat with 6 writes. Required: `sDrop`=1, and 0x06 never appears on the line.
- Write while full coinciding with a pop: fill the FIFO, then assert `lowWr` at the exact stop-bit end edge.
  - Required: the word is accepted, count stays at FIFODEPTH, `sDrop` stays 0.
- Reset mid-frame: write 0xFF and assert `lowRst`=0 at cycle 45 of the frame.
  - Required: `sTx`=1 on the next edge and the FIFO is empty.
  - Required: after release, no further frame unless a new write occurs.
